// File: rtl/btn_debounce_bank.sv
// Multi-channel button debouncer: per-bit synchroniser, shared sample-tick prescaler
// and per-channel stability counter producing a clean level plus press/release pulses.
module btn_debounce_bank #(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 62500,
    parameter int STABLE_TICKS = 100,
    parameter int SYNC_STAGES  = 2,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_state,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic            o_tick
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
    localparam logic              IDLE_BIT  = (ACTIVE_LOW != 0);
    localparam logic [N_CH-1:0]   IDLE_VEC  = {N_CH{IDLE_BIT}};

    // Sample-tick prescaler; a single-cycle divider keeps the counter pinned at 0.
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign o_tick = (tick_cnt_q == TICK_LAST);

    // Synchroniser chain; resetting to the idle pin level avoids a false event after reset.
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
    logic [N_CH-1:0]                  s_log;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_btn};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{IDLE_VEC}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s_log = sync_q[SYNC_STAGES-1] ^ IDLE_VEC;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             state_q, state_d;
            logic             rise_q, rise_d;
            logic             fall_q, fall_d;

            // Any agreeing tick clears the count: acceptance needs an unbroken run.
            always_comb begin
                cnt_d   = cnt_q;
                state_d = state_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                if (o_tick) begin
                    if (s_log[gi] == state_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = s_log[gi];
                        rise_d  = s_log[gi];
                        fall_d  = ~s_log[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    cnt_q   <= '0;
                    state_q <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    state_q <= state_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign o_state[gi] = state_q;
            assign o_rise[gi]  = rise_q;
            assign o_fall[gi]  = fall_q;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Scoreboard bench for btn_debounce_bank: one unprescaled active-high instance and one
// prescaled active-low instance, each with its own expected-pulse queue and monitor.
module tb_btn_debounce_bank;

    typedef struct {
        int         lo;
        int         hi;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] state;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] btn_a, btn_b;
    logic [3:0] state_a, rise_a, fall_a;
    logic [3:0] state_b, rise_b, fall_b;
    logic       tick_a, tick_b;

    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    btn_debounce_bank #(
        .N_CH(4), .TICK_DIV(1), .STABLE_TICKS(3), .SYNC_STAGES(2), .ACTIVE_LOW(0)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_btn(btn_a),
        .o_state(state_a), .o_rise(rise_a), .o_fall(fall_a), .o_tick(tick_a)
    );

    btn_debounce_bank #(
        .N_CH(4), .TICK_DIV(4), .STABLE_TICKS(3), .SYNC_STAGES(2), .ACTIVE_LOW(1)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_btn(btn_b),
        .o_state(state_b), .o_rise(rise_b), .o_fall(fall_b), .o_tick(tick_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic push_a(input int lo, input int hi, input logic [3:0] r,
                          input logic [3:0] f, input logic [3:0] s);
        exp_t e;
        e.lo = lo; e.hi = hi; e.rise = r; e.fall = f; e.state = s;
        q_a.push_back(e);
        $display("push A: edges [%0d,%0d] rise=%b fall=%b state=%b", lo, hi, r, f, s);
    endtask

    task automatic push_b(input int lo, input int hi, input logic [3:0] r,
                          input logic [3:0] f, input logic [3:0] s);
        exp_t e;
        e.lo = lo; e.hi = hi; e.rise = r; e.fall = f; e.state = s;
        q_b.push_back(e);
        $display("push B: edges [%0d,%0d] rise=%b fall=%b state=%b", lo, hi, r, f, s);
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, got, want, edge_n);
        end
    endtask

    // Monitor for instance A: every pulse pops and is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0 && edge_n > q_a[0].hi) begin
                e = q_a.pop_front();
                checks++; errors++;
                $display("FAIL A_missing: no pulse by edge %0d, expected rise=%b fall=%b in [%0d,%0d]",
                         edge_n, e.rise, e.fall, e.lo, e.hi);
            end
            if ((rise_a | fall_a) != 4'b0) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL A_unexpected: rise=%b fall=%b at edge %0d, expected no pulse",
                             rise_a, fall_a, edge_n);
                end else begin
                    e = q_a.pop_front();
                    if (edge_n < e.lo || edge_n > e.hi || rise_a !== e.rise ||
                        fall_a !== e.fall || state_a !== e.state) begin
                        errors++;
                        $display("FAIL A_pulse: edge %0d rise=%b fall=%b state=%b, expected edges [%0d,%0d] rise=%b fall=%b state=%b",
                                 edge_n, rise_a, fall_a, state_a, e.lo, e.hi, e.rise, e.fall, e.state);
                    end else begin
                        $display("A pulse ok: edge %0d rise=%b fall=%b state=%b", edge_n, rise_a, fall_a, state_a);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_b.size() > 0 && edge_n > q_b[0].hi) begin
                e = q_b.pop_front();
                checks++; errors++;
                $display("FAIL B_missing: no pulse by edge %0d, expected rise=%b fall=%b in [%0d,%0d]",
                         edge_n, e.rise, e.fall, e.lo, e.hi);
            end
            if ((rise_b | fall_b) != 4'b0) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL B_unexpected: rise=%b fall=%b at edge %0d, expected no pulse",
                             rise_b, fall_b, edge_n);
                end else begin
                    e = q_b.pop_front();
                    if (edge_n < e.lo || edge_n > e.hi || rise_b !== e.rise ||
                        fall_b !== e.fall || state_b !== e.state) begin
                        errors++;
                        $display("FAIL B_pulse: edge %0d rise=%b fall=%b state=%b, expected edges [%0d,%0d] rise=%b fall=%b state=%b",
                                 edge_n, rise_b, fall_b, state_b, e.lo, e.hi, e.rise, e.fall, e.state);
                    end else begin
                        $display("B pulse ok: edge %0d rise=%b fall=%b state=%b", edge_n, rise_b, fall_b, state_b);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int last_tick;
        int n_ticks;

        rst   = 1'b1;
        btn_a = 4'b0000;
        btn_b = 4'b1111;

        // Reset state
        for (int i = 0; i < 5; i++) begin
            step(1);
            check4("rst_state_a", state_a, 4'b0000);
            check4("rst_pulse_a", rise_a | fall_a, 4'b0000);
            check4("rst_state_b", state_b, 4'b0000);
            check4("rst_pulse_b", rise_b | fall_b, 4'b0000);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check4("idle_state_a", state_a, 4'b0000);
            check4("idle_tick_a", {3'b000, tick_a}, 4'b0001);
            check4("idle_state_b", state_b, 4'b0000);
        end

        // Clean press and release on ch0
        n = edge_n; btn_a = 4'b0001; push_a(n + 5, n + 5, 4'b0001, 4'b0000, 4'b0001);
        step(20);
        check4("press_state", state_a, 4'b0001);
        n = edge_n; btn_a = 4'b0000; push_a(n + 5, n + 5, 4'b0000, 4'b0001, 4'b0000);
        step(20);
        check4("release_state", state_a, 4'b0000);

        // Two-cycle glitch on ch1 is rejected
        btn_a = 4'b0010; step(2);
        btn_a = 4'b0000; step(12);
        check4("glitch_state", state_a, 4'b0000);

        // Bounce 1,0,1,0 then steady 1: one rise four edges after the steady capture
        btn_a = 4'b0010; step(1);
        btn_a = 4'b0000; step(1);
        btn_a = 4'b0010; step(1);
        btn_a = 4'b0000; step(1);
        n = edge_n; btn_a = 4'b0010; push_a(n + 5, n + 5, 4'b0010, 4'b0000, 4'b0010);
        step(12);
        check4("bounce_state", state_a, 4'b0010);

        // Simultaneous channels: settle ch2, then ch0/ch3 rise while ch2 falls
        n = edge_n; btn_a = 4'b0110; push_a(n + 5, n + 5, 4'b0100, 4'b0000, 4'b0110);
        step(12);
        n = edge_n; btn_a = 4'b1011; push_a(n + 5, n + 5, 4'b1001, 4'b0100, 4'b1011);
        step(12);
        check4("simul_state", state_a, 4'b1011);
        n = edge_n; btn_a = 4'b0000; push_a(n + 5, n + 5, 4'b0000, 4'b1011, 4'b0000);
        step(12);

        // Reset pulse at e0+3 discards the count and clears the synchroniser
        n = edge_n; btn_a = 4'b0100;
        step(3); rst = 1'b1;
        step(1); rst = 1'b0;
        check4("midrst_state", state_a, 4'b0000);
        push_a(n + 9, n + 9, 4'b0100, 4'b0000, 4'b0100);
        step(12);
        check4("midrst_after", state_a, 4'b0100);
        n = edge_n; btn_a = 4'b0000; push_a(n + 5, n + 5, 4'b0000, 4'b0100, 4'b0000);
        step(12);

        // Prescaled active-low instance: tick period 4
        last_tick = -1;
        n_ticks   = 0;
        for (int i = 0; i < 16; i++) begin
            if (tick_b) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (edge_n - last_tick != 4) begin
                        errors++;
                        $display("FAIL tick_period: got %0d expected 4", edge_n - last_tick);
                    end
                end
                last_tick = edge_n;
                n_ticks++;
            end
            step(1);
        end
        checks++;
        if (n_ticks != 4) begin
            errors++;
            $display("FAIL tick_count: got %0d expected 4 in 16 cycles", n_ticks);
        end

        n = edge_n; btn_b = 4'b1110; push_b(n + 11, n + 14, 4'b0001, 4'b0000, 4'b0001);
        step(25);
        check4("b_press_state", state_b, 4'b0001);
        n = edge_n; btn_b = 4'b1111; push_b(n + 11, n + 14, 4'b0000, 4'b0001, 4'b0000);
        step(25);
        check4("b_release_state", state_b, 4'b0000);

        // Seven-cycle low pulse spans at most two ticks and must be rejected
        btn_b = 4'b1101; step(7);
        btn_b = 4'b1111; step(30);
        check4("b_glitch_state", state_b, 4'b0000);

        step(2);
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL a_queue_empty: got %0d pending expected 0", q_a.size());
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL b_queue_empty: got %0d pending expected 0", q_b.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
